// File: rtl/rgb_led_arbiter.sv
// Round-robin, time-sliced owner of the shared RGB LED with a minimum display quantum.
// Optional PWM dimming is enabled by defining RGB_LED_ARB_PWM_EN.
module rgb_led_arbiter #(
    parameter int   CLK_FREQUENCY   = 48000000,
    parameter int   NUM_REQ         = 4,
    parameter int   HOLD_MS         = 250,
    parameter int   GAP_CYCLES      = 16,
    parameter int   PWM_BITS        = 8,
    parameter logic RGB_LOGIC_LEVEL = 1'b0
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [3*NUM_REQ-1:0]         color,
    input  logic [PWM_BITS*NUM_REQ-1:0]  level,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    output logic                         rgb_led0_r,
    output logic                         rgb_led0_g,
    output logic                         rgb_led0_b
);

    localparam int HOLD_CYCLES = CLK_FREQUENCY / 1000 * HOLD_MS;
    localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int OWN_W       = $clog2(NUM_REQ);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [OWN_W-1:0]  PTR_RST   = OWN_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

    state_t               r_state, w_state_nxt;
    logic [OWN_W-1:0]     r_owner, w_owner_nxt;
    logic [OWN_W-1:0]     r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0]    r_hold, w_hold_nxt;
    logic [GAP_W-1:0]     r_gap, w_gap_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [2:0]           r_color;
    logic                 r_led_r, r_led_g, r_led_b;

    logic                 w_pick_vld;
    logic [OWN_W-1:0]     w_pick_idx;
    logic [NUM_REQ-1:0]   w_own_mask;
    logic                 w_own_req;
    logic                 w_others;
    logic                 w_latch_en;
    logic [OWN_W-1:0]     w_latch_idx;
    logic                 w_pwm_on;
    logic                 w_lit;

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int               j;
            logic [OWN_W-1:0] idx;
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = OWN_W'(j);
            if (!w_pick_vld && req[idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = idx;
            end
        end
    end

    assign w_own_mask = NUM_REQ'(1) << r_owner;
    assign w_own_req  = req[r_owner];
    assign w_others   = |(req & ~w_own_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gap_nxt   = r_gap;
        w_gnt_nxt   = r_gnt;
        w_latch_en  = 1'b0;
        w_latch_idx = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_SHOW;
                    w_owner_nxt = w_pick_idx;
                    w_ptr_nxt   = w_pick_idx;
                    w_gnt_nxt   = NUM_REQ'(1) << w_pick_idx;
                    w_hold_nxt  = '0;
                    w_latch_en  = 1'b1;
                    w_latch_idx = w_pick_idx;
                end
            end
            S_SHOW: begin
                // Live update only while the owner keeps requesting; otherwise the last value is held.
                w_latch_en = w_own_req;
                if (r_hold == HOLD_LAST) begin
                    if (w_own_req && !w_others) begin
                        w_hold_nxt = '0;
                    end else begin
                        w_state_nxt = S_BLANK;
                        w_gnt_nxt   = '0;
                        w_gap_nxt   = '0;
                    end
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            S_BLANK: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= PTR_RST;
            r_hold  <= '0;
            r_gap   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gap   <= w_gap_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch_en) r_color <= color[3*w_latch_idx +: 3];
    end

`ifdef RGB_LED_ARB_PWM_EN
    logic [PWM_BITS-1:0] r_pwm;
    logic [PWM_BITS-1:0] r_level;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) r_pwm <= '0;
        else         r_pwm <= r_pwm + PWM_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (w_latch_en) r_level <= level[PWM_BITS*w_latch_idx +: PWM_BITS];
    end

    assign w_pwm_on = (r_pwm < r_level);
`else
    // Without dimming the channels are fully on; level is referenced only to keep the port tied off.
    assign w_pwm_on = 1'b1 | (^level);
`endif

    assign w_lit = (r_state == S_SHOW) && w_pwm_on;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_led_r <= ~RGB_LOGIC_LEVEL;
            r_led_g <= ~RGB_LOGIC_LEVEL;
            r_led_b <= ~RGB_LOGIC_LEVEL;
        end else begin
            r_led_r <= (w_lit && r_color[2]) ? RGB_LOGIC_LEVEL : ~RGB_LOGIC_LEVEL;
            r_led_g <= (w_lit && r_color[1]) ? RGB_LOGIC_LEVEL : ~RGB_LOGIC_LEVEL;
            r_led_b <= (w_lit && r_color[0]) ? RGB_LOGIC_LEVEL : ~RGB_LOGIC_LEVEL;
        end
    end

    assign gnt        = r_gnt;
    assign busy       = (r_state != S_IDLE);
    assign rgb_led0_r = r_led_r;
    assign rgb_led0_g = r_led_g;
    assign rgb_led0_b = r_led_b;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter: HOLD_CYCLES=8, GAP_CYCLES=2, active-low pads.
module tb_rgb_led_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] color = '0;
    logic [31:0] level = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic        rgb_led0_r, rgb_led0_g, rgb_led0_b;

    int checks = 0;
    int errors = 0;

    rgb_led_arbiter #(
        .CLK_FREQUENCY  (4000),
        .NUM_REQ        (4),
        .HOLD_MS        (2),
        .GAP_CYCLES     (2),
        .PWM_BITS       (8),
        .RGB_LOGIC_LEVEL(1'b0)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .color     (color),
        .level     (level),
        .gnt       (gnt),
        .busy      (busy),
        .rgb_led0_r(rgb_led0_r),
        .rgb_led0_g(rgb_led0_g),
        .rgb_led0_b(rgb_led0_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  req;
        logic [11:0] color;
        logic [3:0]  gnt;
        logic        busy;
        logic [2:0]  rgb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic [3:0] r, logic [11:0] c,
                                logic [3:0] g, logic b, logic [2:0] p);
        vec_t v;
        v.req = r; v.color = c; v.gnt = g; v.busy = b; v.rgb = p;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pads();
        return {rgb_led0_r, rgb_led0_g, rgb_led0_b};
    endfunction

    // Requester colors {r3..r0}: 001, 010, 100, 111; pads are active-low.
    logic [11:0] CRR = 12'h2A7;
    logic [2:0]  lit_rr [4] = '{3'b000, 3'b011, 3'b101, 3'b110};

    initial begin
        // Round robin with all four requesting.
        for (int i = 0; i < 4; i++) begin
            add(1, 4'hF, CRR, 4'(1 << i), 1'b1, 3'b111);
            add(7, 4'hF, CRR, 4'(1 << i), 1'b1, lit_rr[i]);
            add(1, 4'hF, CRR, 4'h0, 1'b1, lit_rr[i]);
            add(1, 4'hF, CRR, 4'h0, 1'b1, 3'b111);
            add(1, 4'hF, CRR, 4'h0, 1'b0, 3'b111);
        end
        add(1, 4'hF, CRR, 4'h1, 1'b1, 3'b111);
        add(7, 4'h0, CRR, 4'h1, 1'b1, 3'b000);
        add(1, 4'h0, CRR, 4'h0, 1'b1, 3'b000);
        add(1, 4'h0, CRR, 4'h0, 1'b1, 3'b111);
        add(3, 4'h0, CRR, 4'h0, 1'b0, 3'b111);
        // Single owner (req2, green) re-granted with no gap for 40 cycles.
        add(1,  4'h4, 12'h080, 4'h4, 1'b1, 3'b111);
        add(39, 4'h4, 12'h080, 4'h4, 1'b1, 3'b101);
        add(1,  4'h0, 12'h080, 4'h0, 1'b1, 3'b101);
        add(1,  4'h0, 12'h080, 4'h0, 1'b1, 3'b111);
        add(1,  4'h0, 12'h080, 4'h0, 1'b0, 3'b111);
        // One-cycle pulse on req1 (red) still gets a full quantum; color frozen after drop.
        add(1, 4'h2, 12'h020, 4'h2, 1'b1, 3'b111);
        add(7, 4'h0, 12'h008, 4'h2, 1'b1, 3'b011);
        add(1, 4'h0, 12'h008, 4'h0, 1'b1, 3'b011);
        add(1, 4'h0, 12'h008, 4'h0, 1'b1, 3'b111);
        add(1, 4'h0, 12'h008, 4'h0, 1'b0, 3'b111);
        // Live update on req0: red -> blue reaches the pads two edges later.
        add(1, 4'h1, 12'h004, 4'h1, 1'b1, 3'b111);
        add(3, 4'h1, 12'h004, 4'h1, 1'b1, 3'b011);
        add(1, 4'h1, 12'h001, 4'h1, 1'b1, 3'b011);
        add(3, 4'h1, 12'h001, 4'h1, 1'b1, 3'b110);
        add(1, 4'h1, 12'h001, 4'h1, 1'b1, 3'b110);
        add(7, 4'h0, 12'h001, 4'h1, 1'b1, 3'b110);
        add(1, 4'h0, 12'h001, 4'h0, 1'b1, 3'b110);
        add(1, 4'h0, 12'h001, 4'h0, 1'b1, 3'b111);
        add(1, 4'h0, 12'h001, 4'h0, 1'b0, 3'b111);

        #2 sys_rst = 1'b1;
        #1;
        check("rst_gnt", gnt, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_pads", pads(), 3'b111);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_gnt", gnt, 4'h0);
        @(negedge clk);
        sys_rst = 1'b0;

`ifdef RGB_LED_ARB_PWM_EN
        begin
            int lows;
            req = 4'h1; color = 12'h001; level = 32'h0000_0040;
            repeat (300) @(posedge clk);
            lows = 0;
            for (int k = 0; k < 512; k++) begin
                @(posedge clk); #1;
                if (rgb_led0_b == 1'b0) lows++;
            end
            check("pwm_64_lows", lows, 128);
            check("pwm_gnt", gnt, 4'h1);
            level = 32'h0;
            repeat (4) @(posedge clk);
            lows = 0;
            for (int k = 0; k < 256; k++) begin
                @(posedge clk); #1;
                if (rgb_led0_b == 1'b0) lows++;
            end
            check("pwm_0_lows", lows, 0);
            req = 4'h0;
            repeat (20) @(posedge clk);
            #1;
            check("pwm_idle_busy", busy, 1'b0);
        end
`else
        for (int v = 0; v < vecs.size(); v++) begin
            req   = vecs[v].req;
            color = vecs[v].color;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gnt", v), gnt, vecs[v].gnt);
            check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
            check($sformatf("v%0d_pads", v), pads(), vecs[v].rgb);
        end
`endif

        // Asynchronous reset mid-SHOW, then requester 0 wins right after release.
        req = 4'hF; color = 12'hFFF; level = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("pre_rst_gnt", gnt, 4'h2);
        repeat (3) @(posedge clk);
        #3 sys_rst = 1'b1;
        #1;
        check("async_rst_gnt", gnt, 4'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_pads", pads(), 3'b111);
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_gnt", gnt, 4'h1);
        check("post_rst_busy", busy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
